// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: in-order imem requests, credit-limited prefetch FIFO, redirect flush.
module fetch_stage #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_ir,
    output logic [31:0] if_id_npc,
    output logic [31:0] if_id_pc,
    output logic        protocol_err
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   rsp_pc;
    logic [31:0]   fifo_pc [DEPTH];
    logic [31:0]   fifo_ir [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW:0]   credits_used;
    logic          req_fire;
    logic          rsp_accept;
    logic          rsp_keep;
    logic          pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every outstanding request owns a FIFO slot, so a returning word always fits.
    assign credits_used   = {1'b0, fifo_count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_accept     = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep       = rsp_accept && (drop_cnt == '0) && !redirect_valid;
    assign pop            = !redirect_valid && !stall && (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rsp_keep) begin
            fifo_pc[tail] <= rsp_pc;
            fifo_ir[tail] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            rsp_pc       <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            fifo_count   <= '0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            if_id_valid  <= 1'b0;
            if_id_ir     <= NOP;
            if_id_npc    <= '0;
            if_id_pc     <= '0;
            protocol_err <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_accept);
            if (imem_rsp_valid && (outstanding == '0))
                protocol_err <= 1'b1;

            if (redirect_valid) begin
                // Everything still in flight belongs to the wrong path and is skipped on return.
                fetch_pc    <= redirect_pc;
                rsp_pc      <= redirect_pc;
                head        <= '0;
                tail        <= '0;
                fifo_count  <= '0;
                drop_cnt    <= outstanding - CW'(rsp_accept);
                if_id_valid <= 1'b0;
                if_id_ir    <= NOP;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_accept && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (rsp_keep) begin
                    tail   <= ptr_inc(tail);
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (pop) begin
                    head        <= ptr_inc(head);
                    if_id_valid <= 1'b1;
                    if_id_pc    <= fifo_pc[head];
                    if_id_ir    <= fifo_ir[head];
                    if_id_npc   <= fifo_pc[head] + 32'd4;
                end else if (!stall) begin
                    if_id_valid <= 1'b0;
                    if_id_ir    <= NOP;
                end
                fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized scoreboard bench for fetch_stage with a behavioural memory and PC model.
module tb_fetch_stage;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_ir;
    logic [31:0] if_id_npc;
    logic [31:0] if_id_pc;
    logic        protocol_err;

    fetch_stage #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP(NOP)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
        .if_id_valid(if_id_valid), .if_id_ir(if_id_ir), .if_id_npc(if_id_npc), .if_id_pc(if_id_pc),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] pc; logic [31:0] ir; } exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] key = 32'h0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          inject = 1'b0;
    bit          t1_watch = 1'b0;
    int          first_rsp_edge = -1;
    int          first_valid_edge = -1;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Memory: in-order responses after a per-request latency; also tracks the expected fetch PC.
    initial begin : mem_proc
        logic [31:0] model_pc;
        logic        pv_valid;
        logic [31:0] pv_addr;
        model_pc = RESET_PC;
        pv_valid = 1'b0;
        pv_addr = '0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
                model_pc = RESET_PC;
                pv_valid = 1'b0;
            end else begin
                if (inject) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = 32'hBAD0_BAD0;
                    inject = 1'b0;
                end else if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = pend_q[0].addr ^ key;
                    if (t1_watch && pend_q[0].addr == 32'h0 && first_rsp_edge < 0)
                        first_rsp_edge = cyc + 1;
                    void'(pend_q.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data = $urandom;
                end
                if (pv_valid && !redirect_valid) begin
                    chk(imem_req_valid === 1'b1, "req_valid_held", 32'(imem_req_valid), 32'd1);
                    chk(imem_req_addr === pv_addr, "req_addr_held", imem_req_addr, pv_addr);
                end
                if (redirect_valid) begin
                    chk(imem_req_valid === 1'b0, "req_valid_during_redirect", 32'(imem_req_valid), 32'd0);
                    model_pc = redirect_pc;
                    pv_valid = 1'b0;
                end else begin
                    pv_valid = imem_req_valid && !imem_req_ready;
                    pv_addr = imem_req_addr;
                    if (imem_req_valid && imem_req_ready) begin
                        chk(imem_req_addr === model_pc, "req_addr", imem_req_addr, model_pc);
                        exp_q.push_back('{model_pc, model_pc ^ key});
                        pend_q.push_back('{imem_req_addr, cyc + 1 + int'($urandom_range(lat_max, lat_min))});
                        model_pc = model_pc + 32'd4;
                    end
                end
            end
        end
    end

    // Monitor: judges the IF/ID register after each edge from what was driven into that edge.
    initial begin : monitor
        bit          s_reset;
        bit          s_stall;
        bit          s_redir;
        logic        h_valid;
        logic [31:0] h_ir;
        logic [31:0] h_pc;
        logic [31:0] h_npc;
        exp_t        e;
        s_reset = 1'b1;
        s_stall = 1'b0;
        s_redir = 1'b0;
        forever begin
            @(negedge clk);
            if (s_reset) begin
                chk(if_id_valid === 1'b0, "reset_valid", 32'(if_id_valid), 32'd0);
                chk(if_id_ir === NOP, "reset_ir", if_id_ir, NOP);
                chk(if_id_pc === 32'h0, "reset_pc", if_id_pc, 32'h0);
                chk(if_id_npc === 32'h0, "reset_npc", if_id_npc, 32'h0);
                chk(protocol_err === 1'b0, "reset_protocol_err", 32'(protocol_err), 32'd0);
            end else if (s_redir) begin
                chk(if_id_valid === 1'b0, "redirect_bubble_valid", 32'(if_id_valid), 32'd0);
                chk(if_id_ir === NOP, "redirect_bubble_ir", if_id_ir, NOP);
            end else if (s_stall) begin
                chk(if_id_valid === h_valid, "stall_hold_valid", 32'(if_id_valid), 32'(h_valid));
                chk(if_id_ir === h_ir, "stall_hold_ir", if_id_ir, h_ir);
                chk(if_id_pc === h_pc, "stall_hold_pc", if_id_pc, h_pc);
                chk(if_id_npc === h_npc, "stall_hold_npc", if_id_npc, h_npc);
            end else if (if_id_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_instr", if_id_pc, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk(if_id_pc === e.pc, "if_id_pc", if_id_pc, e.pc);
                    chk(if_id_ir === e.ir, "if_id_ir", if_id_ir, e.ir);
                    chk(if_id_npc === e.pc + 32'd4, "if_id_npc", if_id_npc, e.pc + 32'd4);
                end
                if (t1_watch && first_valid_edge < 0) first_valid_edge = cyc;
            end else begin
                chk(if_id_ir === NOP, "bubble_ir", if_id_ir, NOP);
            end
            if (reset) begin
                chk(imem_req_valid === 1'b0, "req_valid_in_reset", 32'(imem_req_valid), 32'd0);
                exp_q.delete();
            end else if (redirect_valid) begin
                exp_q.delete();
            end
            s_reset = reset;
            s_stall = stall;
            s_redir = redirect_valid;
            h_valid = if_id_valid;
            h_ir = if_id_ir;
            h_pc = if_id_pc;
            h_npc = if_id_npc;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] new_key);
        reset = 1'b1;
        key = new_key;
        step(2);
        reset = 1'b0;
    endtask

    initial begin : stimulus
        bit found;
        reset = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b0;
        t1_watch = 1'b1;
        step(3);

        // T1: 1-cycle memory returning the address as data
        imem_req_ready = 1'b1;
        reset = 1'b0;
        step(12);
        chk(first_rsp_edge >= 0 && first_valid_edge == first_rsp_edge + 1, "t1_latency",
            32'(first_valid_edge), 32'(first_rsp_edge + 1));
        t1_watch = 1'b0;

        // T2: decode stall fills the credits
        stall = 1'b1;
        step(6);
        chk(imem_req_valid === 1'b0, "t2_credit_full", 32'(imem_req_valid), 32'd0);
        stall = 1'b0;
        step(15);

        // T3: latency 3, redirect with two requests in flight
        lat_min = 3;
        lat_max = 3;
        do_reset(32'h5A5A_0F0F);
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0100;
        step(1);
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (if_id_valid) found = 1'b1;
        end
        chk(found && if_id_pc === 32'h100, "t3_target_pc", if_id_pc, 32'h100);
        chk(found && if_id_ir === (32'h100 ^ key), "t3_target_ir", if_id_ir, 32'h100 ^ key);
        step(10);

        // T4: redirect together with stall
        stall = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        step(1);
        redirect_valid = 1'b0;
        step(2);
        stall = 1'b0;
        step(12);

        // T5: random ready/stall/latency with occasional redirects
        lat_min = 1;
        lat_max = 3;
        do_reset(32'hC3A5_1E2D);
        for (int i = 0; i < 500; i++) begin
            imem_req_ready = 1'($urandom_range(1, 0));
            stall = ($urandom_range(3, 0) == 0);
            redirect_valid = ($urandom_range(24, 0) == 0);
            redirect_pc = $urandom & 32'hFFFF_FFFC;
            step(1);
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        imem_req_ready = 1'b1;
        step(15);

        // T6: spurious response with nothing outstanding
        imem_req_ready = 1'b0;
        lat_min = 1;
        lat_max = 1;
        do_reset(32'h0F0F_0000);
        step(2);
        inject = 1'b1;
        step(4);
        chk(protocol_err === 1'b1, "t6_protocol_err_set", 32'(protocol_err), 32'd1);
        chk(if_id_valid === 1'b0, "t6_fifo_unchanged", 32'(if_id_valid), 32'd0);
        imem_req_ready = 1'b1;
        step(15);
        chk(protocol_err === 1'b1, "t6_protocol_err_sticky", 32'(protocol_err), 32'd1);
        reset = 1'b1;
        step(2);
        chk(protocol_err === 1'b0, "t6_protocol_err_cleared", 32'(protocol_err), 32'd0);
        reset = 1'b0;
        step(5);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
